// File: rtl/tm_input_sequencer_if.sv
// Rule-memory write port and datapath step handshake seen by the input sequencer.
// master = sequencer side, slave = rule memory / step datapath side.
interface tm_input_sequencer_if #(
    parameter int DATA_W    = 4,
    parameter int FIELDS    = 4,
    parameter int MAX_RULES = 8
);
    logic                                rule_we;
    logic [$clog2(MAX_RULES)-1:0]        rule_addr;
    logic [FIELDS-1:0][DATA_W-1:0]       rule_data;
    logic                                step;
    logic                                step_ack;
    logic                                halted;

    modport master (
        output rule_we, rule_addr, rule_data, step,
        input  step_ack, halted
    );

    modport slave (
        input  rule_we, rule_addr, rule_data, step,
        output step_ack, halted
    );
endinterface

// File: rtl/tm_input_sequencer.sv
// Turing machine front end: conditions Next/Done buttons, assembles rule-table writes
// in LOAD, issues single-step requests in IDLE/STEP and reports completion in HALT.

// One button lane: 2-flop synchronizer plus history flop; fires once per press.
module tm_btn_cond (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic evt
);
    logic [1:0] sync_q, sync_d;
    logic       hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[0], btn};
        hist_d = sync_q[1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign evt = sync_q[1] & ~hist_q;
endmodule

module tm_input_sequencer #(
    parameter int DATA_W    = 4,
    parameter int FIELDS    = 4,
    parameter int MAX_RULES = 8,
    parameter int MAX_STEPS = 64
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  input_data,
    input  logic                               Next,
    input  logic                               Done,
    tm_input_sequencer_if.master               bus,
    output logic [$clog2(FIELDS)-1:0]          field_idx,
    output logic [$clog2(MAX_RULES):0]         rule_count,
    output logic                               running,
    output logic [$clog2(MAX_STEPS+1)-1:0]     step_count,
    output logic                               load_err,
    output logic                               Compute_done
);
    localparam int FI_W = $clog2(FIELDS);
    localparam int AW   = $clog2(MAX_RULES);
    localparam int RC_W = AW + 1;
    localparam int SC_W = $clog2(MAX_STEPS + 1);
    localparam logic [FI_W-1:0] LAST_FIELD = FI_W'(FIELDS - 1);

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_STEP, S_HALT} state_t;

    state_t                        state_q, state_d;
    logic [FIELDS-1:0][DATA_W-1:0] fields_q, fields_d;
    logic [FI_W-1:0]               field_idx_q, field_idx_d;
    logic [RC_W-1:0]               rule_count_q, rule_count_d;
    logic                          rule_we_q, rule_we_d;
    logic [AW-1:0]                 rule_addr_q, rule_addr_d;
    logic [FIELDS-1:0][DATA_W-1:0] rule_data_q, rule_data_d;
    logic                          step_q, step_d;
    logic [SC_W-1:0]               step_count_q, step_count_d;
    logic                          load_err_q, load_err_d;
    logic                          done_q, done_d;

    // Lane 0 = Next, lane 1 = Done.
    logic [1:0] btn_raw, btn_evt;
    assign btn_raw = {Done, Next};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        tm_btn_cond u_cond (
            .clock (clock),
            .reset (reset),
            .btn   (btn_raw[g]),
            .evt   (btn_evt[g])
        );
    end

    // Done has priority: a coincident Next event is dropped.
    logic done_evt, next_evt;
    assign done_evt = btn_evt[1];
    assign next_evt = btn_evt[0] & ~btn_evt[1];

    logic [SC_W-1:0] step_count_inc;
    logic            step_limit_hit;
    assign step_count_inc = (step_count_q == SC_W'(MAX_STEPS)) ? step_count_q
                                                               : step_count_q + SC_W'(1);
    assign step_limit_hit = (step_count_inc == SC_W'(MAX_STEPS));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            fields_q     <= '0;
            field_idx_q  <= '0;
            rule_count_q <= '0;
            rule_we_q    <= 1'b0;
            rule_addr_q  <= '0;
            rule_data_q  <= '0;
            step_q       <= 1'b0;
            step_count_q <= '0;
            load_err_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fields_q     <= fields_d;
            field_idx_q  <= field_idx_d;
            rule_count_q <= rule_count_d;
            rule_we_q    <= rule_we_d;
            rule_addr_q  <= rule_addr_d;
            rule_data_q  <= rule_data_d;
            step_q       <= step_d;
            step_count_q <= step_count_d;
            load_err_q   <= load_err_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: if (done_evt && rule_count_q != '0) state_d = S_IDLE;
            S_IDLE: if (next_evt) state_d = S_STEP;
            S_STEP: if (bus.step_ack) state_d = (bus.halted || step_limit_hit) ? S_HALT : S_IDLE;
            S_HALT: if (done_evt) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        fields_d     = fields_q;
        field_idx_d  = field_idx_q;
        rule_count_d = rule_count_q;
        rule_we_d    = 1'b0;
        rule_addr_d  = rule_addr_q;
        rule_data_d  = rule_data_q;
        step_d       = 1'b0;
        step_count_d = step_count_q;
        load_err_d   = load_err_q;
        done_d       = done_q;

        unique case (state_q)
            S_LOAD: begin
                if (done_evt) begin
                    if (field_idx_q != '0) begin
                        field_idx_d = '0;
                        load_err_d  = 1'b1;
                    end
                    if (rule_count_q == '0) load_err_d = 1'b1;
                end else if (next_evt) begin
                    fields_d[field_idx_q] = input_data;
                    if (field_idx_q == LAST_FIELD) begin
                        // The rule is registered even when the table is full.
                        rule_data_d = fields_d;
                        field_idx_d = '0;
                        if (rule_count_q < RC_W'(MAX_RULES)) begin
                            rule_we_d    = 1'b1;
                            rule_addr_d  = rule_count_q[AW-1:0];
                            rule_count_d = rule_count_q + RC_W'(1);
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end else begin
                        field_idx_d = field_idx_q + FI_W'(1);
                    end
                end
            end
            S_IDLE: if (next_evt) step_d = 1'b1;
            S_STEP: begin
                if (bus.step_ack) begin
                    step_count_d = step_count_inc;
                    if (bus.halted || step_limit_hit) done_d = 1'b1;
                end
            end
            S_HALT: begin
                if (done_evt) begin
                    rule_count_d = '0;
                    step_count_d = '0;
                    field_idx_d  = '0;
                    load_err_d   = 1'b0;
                    done_d       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        running       = (state_q == S_IDLE) || (state_q == S_STEP);
        bus.rule_we   = rule_we_q;
        bus.rule_addr = rule_addr_q;
        bus.rule_data = rule_data_q;
        bus.step      = step_q;
        field_idx     = field_idx_q;
        rule_count    = rule_count_q;
        step_count    = step_count_q;
        load_err      = load_err_q;
        Compute_done  = done_q;
    end
endmodule

// File: tb/tb_tm_input_sequencer.sv
// Directed plus randomized bench for tm_input_sequencer against an event-level model.
module tb_tm_input_sequencer;
    localparam int DATA_W    = 4;
    localparam int FIELDS    = 4;
    localparam int MAX_RULES = 2;
    localparam int MAX_STEPS = 4;

    localparam int P_LOAD = 0, P_IDLE = 1, P_STEP = 2, P_HALT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] input_data = '0;
    logic       Next = 1'b0;
    logic       Done = 1'b0;
    logic [1:0] field_idx;
    logic [1:0] rule_count;
    logic       running;
    logic [2:0] step_count;
    logic       load_err;
    logic       Compute_done;

    tm_input_sequencer_if #(.DATA_W(DATA_W), .FIELDS(FIELDS), .MAX_RULES(MAX_RULES)) bus ();

    tm_input_sequencer #(
        .DATA_W(DATA_W), .FIELDS(FIELDS), .MAX_RULES(MAX_RULES), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .input_data   (input_data),
        .Next         (Next),
        .Done         (Done),
        .bus          (bus),
        .field_idx    (field_idx),
        .rule_count   (rule_count),
        .running      (running),
        .step_count   (step_count),
        .load_err     (load_err),
        .Compute_done (Compute_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Observed traffic
    int obs_addr[$];
    int obs_data[$];
    int step_pulses = 0;
    int step_wide = 0;
    logic step_prev = 1'b0;

    always @(negedge clock) begin
        if (bus.rule_we === 1'b1) begin
            obs_addr.push_back(int'(bus.rule_addr));
            obs_data.push_back(int'(bus.rule_data));
        end
        if (bus.step === 1'b1) step_pulses <= step_pulses + 1;
        if (bus.step === 1'b1 && step_prev === 1'b1) step_wide <= step_wide + 1;
        step_prev <= bus.step;
    end

    // Event-level reference model
    int m_phase = P_LOAD, m_fi = 0, m_rc = 0, m_sc = 0, m_err = 0, m_done = 0;
    int m_part = 0, m_steps = 0;
    int exp_addr[$];
    int exp_data[$];

    task automatic m_next(input int d);
        if (m_phase == P_LOAD) begin
            m_part = m_part | (d << (DATA_W * m_fi));
            if (m_fi == FIELDS - 1) begin
                if (m_rc < MAX_RULES) begin
                    exp_addr.push_back(m_rc);
                    exp_data.push_back(m_part);
                    m_rc++;
                end else m_err = 1;
                m_fi = 0;
                m_part = 0;
            end else m_fi++;
        end else if (m_phase == P_IDLE) begin
            m_steps++;
            m_phase = P_STEP;
        end
    endtask

    task automatic m_done_evt();
        if (m_phase == P_LOAD) begin
            if (m_fi != 0) begin m_fi = 0; m_part = 0; m_err = 1; end
            if (m_rc == 0) m_err = 1;
            else m_phase = P_IDLE;
        end else if (m_phase == P_HALT) begin
            m_phase = P_LOAD;
            m_rc = 0; m_sc = 0; m_fi = 0; m_err = 0; m_done = 0; m_part = 0;
        end
    endtask

    task automatic m_ack(input bit h);
        if (m_phase == P_STEP) begin
            if (m_sc < MAX_STEPS) m_sc++;
            if (h || m_sc == MAX_STEPS) begin m_phase = P_HALT; m_done = 1; end
            else m_phase = P_IDLE;
        end
    endtask

    task automatic m_reset();
        m_phase = P_LOAD; m_fi = 0; m_rc = 0; m_sc = 0; m_err = 0; m_done = 0; m_part = 0;
        exp_addr.delete(); exp_data.delete();
        obs_addr.delete(); obs_data.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".field_idx"}, field_idx, m_fi);
        chk({tag, ".rule_count"}, rule_count, m_rc);
        chk({tag, ".step_count"}, step_count, m_sc);
        chk({tag, ".load_err"}, load_err, m_err);
        chk({tag, ".done"}, Compute_done, m_done);
        chk({tag, ".running"}, running, (m_phase == P_IDLE || m_phase == P_STEP));
        chk({tag, ".step_pulses"}, step_pulses, m_steps);
        chk({tag, ".step_wide"}, step_wide, 0);
        chk({tag, ".n_writes"}, obs_addr.size(), exp_addr.size());
        while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
            chk({tag, ".wr_addr"}, obs_addr.pop_front(), exp_addr.pop_front());
            chk({tag, ".wr_data"}, obs_data.pop_front(), exp_data.pop_front());
        end
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    // Called at a negedge; buttons released with enough gap for the history flop to clear.
    task automatic press(input bit nx, input bit dn, input int hold);
        Next = nx;
        Done = dn;
        tick(hold);
        Next = 1'b0;
        Done = 1'b0;
        tick(4);
        if (dn) m_done_evt();
        else if (nx) m_next(int'(input_data));
    endtask

    task automatic enter(input int d);
        input_data = 4'(d);
        press(1'b1, 1'b0, 2);
    endtask

    task automatic ack(input bit h);
        bus.step_ack = 1'b1;
        bus.halted   = h;
        tick(1);
        bus.step_ack = 1'b0;
        bus.halted   = 1'b0;
        tick(2);
        m_ack(h);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int hold;
        bus.step_ack = 1'b0;
        bus.halted   = 1'b0;

        // Reset state
        tick(3);
        chk("rst.rule_we", bus.rule_we, 0);
        chk("rst.step", bus.step, 0);
        chk("rst.rule_addr", bus.rule_addr, 0);
        chk("rst.rule_data", bus.rule_data, 0);
        chk_model("rst");
        reset = 1'b1;
        tick(2);

        // Two rules, directed values
        enter(3); enter(1); enter(0); enter(2);
        chk("t1.first_n", obs_data.size(), 1);
        chk("t1.first_data", (obs_data.size() > 0) ? obs_data[0] : -1, 32'h2013);
        chk("t1.first_addr", (obs_addr.size() > 0) ? obs_addr[0] : -1, 0);
        chk_model("t1a");
        enter(1); enter(0); enter(1); enter(0);
        chk("t1.second_data", (obs_data.size() > 0) ? obs_data[0] : -1, 32'h0101);
        chk("t1.second_addr", (obs_addr.size() > 0) ? obs_addr[0] : -1, 1);
        chk_model("t1b");

        // Long press and 3-edge latency
        input_data = 4'd5;
        Next = 1'b1;
        tick(1); chk("t2.lat_e1", field_idx, 0);
        tick(1); chk("t2.lat_e2", field_idx, 0);
        tick(1); chk("t2.lat_e3", field_idx, 1);
        tick(7);
        Next = 1'b0;
        tick(4);
        m_next(5);
        chk_model("t2");

        // Partial rule then Done -> IDLE with error
        enter(6);
        chk("t3.fi2", field_idx, 2);
        press(1'b0, 1'b1, 2);
        chk_model("t3");

        // Step handshake, second Next dropped while waiting
        press(1'b1, 1'b0, 2);
        chk("t4.one_step", step_pulses, 1);
        press(1'b1, 1'b0, 2);
        tick(3);
        ack(1'b0);
        chk_model("t4");

        // Halt, Next ignored, Done restarts
        press(1'b1, 1'b0, 2);
        ack(1'b1);
        chk_model("t5.halt");
        press(1'b1, 1'b0, 3);
        chk_model("t5.next_in_halt");
        press(1'b0, 1'b1, 2);
        chk_model("t5.restart");

        // Overflow: three rules into a two-entry table
        for (int k = 0; k < 3 * FIELDS; k++) enter($urandom_range(0, 15));
        chk_model("t6.overflow");
        press(1'b0, 1'b1, 2);
        for (int k = 0; k < MAX_STEPS; k++) begin
            press(1'b1, 1'b0, 2);
            ack(1'b0);
            chk_model("t5.limit");
        end
        press(1'b0, 1'b1, 2);
        press(1'b0, 1'b1, 2);
        chk_model("t3.empty_done");

        // Async reset during step pulse
        for (int k = 0; k < FIELDS; k++) enter(k);
        press(1'b0, 1'b1, 2);
        Next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.step === 1'b1) break;
        end
        chk("t6.step_seen", bus.step, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6.rst_step", bus.step, 0);
        chk("t6.rst_we", bus.rule_we, 0);
        chk("t6.rst_done", Compute_done, 0);
        m_next(0);
        Next = 1'b0;
        m_reset();
        tick(2);
        reset = 1'b1;
        tick(2);
        chk_model("t6.after_rst");

        // Async reset during rule_we pulse
        for (int k = 0; k < FIELDS - 1; k++) enter(9);
        Next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.rule_we === 1'b1) break;
        end
        chk("t6.we_seen", bus.rule_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6.rst_we2", bus.rule_we, 0);
        Next = 1'b0;
        m_reset();
        tick(2);
        reset = 1'b1;
        tick(2);

        // Async reset while halted
        for (int k = 0; k < FIELDS; k++) enter(7);
        press(1'b0, 1'b1, 2);
        press(1'b1, 1'b0, 2);
        ack(1'b1);
        chk("t6.done_set", Compute_done, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6.rst_done2", Compute_done, 0);
        m_reset();
        tick(2);
        reset = 1'b1;
        tick(2);
        chk_model("t6.final_rst");

        // Randomized operations
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            hold = $urandom_range(1, 6);
            if (r <= 4) begin
                input_data = 4'($urandom_range(0, 15));
                press(1'b1, 1'b0, hold);
            end else if (r <= 6) press(1'b0, 1'b1, hold);
            else if (r == 7) begin
                input_data = 4'($urandom_range(0, 15));
                press(1'b1, 1'b1, hold);
            end else ack($urandom_range(0, 3) == 0);
            chk_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tm_input_sequencer.md
Name: tm_input_sequencer

Overview:
Front-end controller for the Turing machine datapath.
- Turns the raw Next/Done buttons and the 4-bit input_data switches into rule-table writes during programming.
- Turns the same buttons into single-step requests to the datapath during execution.
- Owns the LOAD -> RUN -> HALT phase sequencing and drives Compute_done.
- Sits between the board I/O and the rule memory / step logic.

Parameters:
DATA_W, 4, width of input_data and of one rule field
FIELDS, 4, fields per rule; field 0 is entered first
MAX_RULES, 8, rule table depth
MAX_STEPS, 64, step limit; reaching it forces halt

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
input_data  in  DATA_W  field value from switches
Next  in  1  raw button, asynchronous level
Done  in  1  raw button, asynchronous level
step_ack  in  1  datapath finished the requested step (1-cycle pulse)
halted  in  1  datapath is in its halt state; valid when step_ack=1
rule_we  out  1  rule memory write strobe, 1 cycle
rule_addr  out  $clog2(MAX_RULES)  write address
rule_data  out  FIELDS*DATA_W  assembled rule; field 0 in LSBs
field_idx  out  $clog2(FIELDS)  next field to be entered
rule_count  out  $clog2(MAX_RULES)+1  rules stored
step  out  1  step request pulse, 1 cycle
running  out  1  state is IDLE or STEP
step_count  out  $clog2(MAX_STEPS+1)  steps completed
load_err  out  1  sticky programming error
Compute_done  out  1  execution finished

Behaviour:
- Reset (reset=0, asynchronous): state=LOAD and every output/counter = 0. This includes rule_we and step, which drop immediately without waiting for a clock edge.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer plus one history flop.
  - Event = sync & ~hist.
  - A button held any number of cycles gives exactly one event.
  - The event is acted on at the 3rd rising edge after the first edge that samples the button high.
- Simultaneous Next and Done events: Done wins; the Next event is discarded.
- LOAD:
  - Next event:
    - Latch input_data into field[field_idx], field_idx++.
    - If field_idx was FIELDS-1:
      - Register rule_data.
      - If rule_count < MAX_RULES: pulse rule_we for the following cycle with rule_addr=rule_count, then rule_count++.
      - Else: no write; set load_err.
      - field_idx=0 in both cases.
  - Done event:
    - If field_idx != 0: discard the partial rule, field_idx=0, load_err=1.
    - If rule_count==0 after that: stay in LOAD with load_err=1.
    - Otherwise -> IDLE.
- IDLE:
  - Next event: step=1 for exactly one cycle, -> STEP.
  - Done event: ignored.
- STEP:
  - Wait for step_ack. Next and Done events are dropped, not queued.
  - On step_ack: step_count++.
  - If halted=1 or the new step_count==MAX_STEPS: -> HALT and Compute_done=1, both registered on the same edge.
  - Else -> IDLE.
  - step_ack outside STEP is ignored.
- HALT:
  - Compute_done held at 1; Next ignored.
  - Done event -> LOAD and clear rule_count, step_count, field_idx, load_err and Compute_done. Rule memory contents are not erased.
- Counter limits:
  - step_count saturates at MAX_STEPS.
  - rule_count never exceeds MAX_RULES.
- load_err clears only on reset or on HALT->LOAD.

Test Plan:
1. Programming, each Next held 2 cycles:
   - Enter 3,1,0,2 -> one rule_we, rule_addr=0, rule_data=16'h2013.
   - Enter 1,0,1,0 -> rule_we, rule_addr=1, rule_data=16'h0101.
   - Then rule_count=2, field_idx=0, load_err=0.
2. Debounce and latency:
   - Next held 10 cycles -> exactly one field captured.
   - field_idx changes on the 3rd edge after Next rises.
3. Partial rule: field_idx=2 when Done pressed -> load_err=1, field_idx=0, running=1, no rule_we.
   - Done with rule_count=0 -> state stays LOAD, load_err=1.
4. Step handshake:
   - In IDLE, press Next -> step high exactly 1 cycle.
   - Press Next again before the ack -> no second step.
   - step_ack 3 cycles later with halted=0 -> step_count=1, Compute_done=0, back in IDLE.
5. Halt, step limit and restart:
   - step_ack with halted=1 -> Compute_done=1.
   - Next in HALT -> no step; Done in HALT -> LOAD, all counts 0, Compute_done=0.
   - Separately, with MAX_STEPS=4 and halted=0: 4 steps -> Compute_done=1.
6. Overflow and reset:
   - MAX_RULES=2, enter 3 full rules -> only addr 0,1 written, load_err=1, rule_count=2.
   - Assert reset mid-STEP -> step, rule_we and Compute_done go to 0 immediately (no clock edge); state LOAD after release.
